// File: rtl/multi_clock_divider_pkg.sv
// Shared definitions for the multi-channel clock divider: default sizing,
// select-width helper, common board ratios and the per-channel output bundle.
package multi_clock_divider_pkg;

    localparam int DEF_CNT_WIDTH = 16;
    localparam int DEF_DIV_RESET = 49999;

    // Divisors are period-minus-one values for the 50 MHz board clock.
    localparam int BOARD_CLK_HZ = 50_000_000;
    localparam int DIV_1KHZ     = (BOARD_CLK_HZ / 1000) - 1;
    localparam int DIV_100HZ    = (BOARD_CLK_HZ / 100) - 1;
    localparam int DIV_1HZ      = BOARD_CLK_HZ - 1;

    typedef struct packed {
        logic tick;
        logic sqw;
    } ch_out_t;

    function automatic int sel_width(input int n);
        int w;
        if (n > 1) begin
            w = $clog2(n);
        end else begin
            w = 1;
        end
        return w;
    endfunction

    function automatic int ratio_to_div(input int src_hz, input int out_hz);
        return (src_hz / out_hz) - 1;
    endfunction

endpackage

// File: rtl/multi_clock_divider_channel.sv
// One divider channel: counter, active and pending divisor, and the registered
// tick / square-wave outputs decoded from the counter state.
module multi_clock_divider_channel
    import multi_clock_divider_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH,
    parameter int DIV_RESET = DEF_DIV_RESET
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 en_i,
    input  logic                 wr_i,
    input  logic [CNT_WIDTH-1:0] div_i,
    input  logic                 sync_i,
    output logic                 tick_o,
    output logic                 clk_o
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] act_q, act_d;
    logic [CNT_WIDTH-1:0] pend_q, pend_d;
    logic                 pf_q, pf_d;
    ch_out_t              out_q, out_d;

    logic                 wrap_s;
    logic                 restart_s;
    logic [CNT_WIDTH:0]   half_s;

    // Next-state logic; a restart (disable or SYNC) beats a wrap.
    always_comb begin
        cnt_d     = cnt_q;
        act_d     = act_q;
        pend_d    = pend_q;
        pf_d      = pf_q;
        wrap_s    = en_i && (cnt_q == act_q);
        restart_s = sync_i || !en_i;
        half_s    = ({1'b0, act_q} + {{CNT_WIDTH{1'b0}}, 1'b1}) >> 1;

        if (restart_s) begin
            cnt_d = '0;
            if (wr_i) begin
                act_d  = div_i;
                pend_d = div_i;
                pf_d   = 1'b0;
            end else if (pf_q) begin
                act_d = pend_q;
                pf_d  = 1'b0;
            end else begin
                act_d = act_q;
            end
        end else if (wrap_s) begin
            cnt_d = '0;
            if (pf_q) begin
                act_d = pend_q;
            end else begin
                act_d = act_q;
            end
            // A load landing on the wrap only becomes pending for the next one.
            if (wr_i) begin
                pend_d = div_i;
                pf_d   = 1'b1;
            end else begin
                pf_d   = 1'b0;
            end
        end else begin
            cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            if (wr_i) begin
                pend_d = div_i;
                pf_d   = 1'b1;
            end else begin
                pend_d = pend_q;
            end
        end

        out_d.tick = wrap_s;
        out_d.sqw  = en_i && ({1'b0, cnt_q} >= half_s);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q  <= '0;
            act_q  <= CNT_WIDTH'(DIV_RESET);
            pend_q <= CNT_WIDTH'(DIV_RESET);
            pf_q   <= 1'b0;
            out_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            pend_q <= pend_d;
            pf_q   <= pf_d;
            out_q  <= out_d;
        end
    end

    assign tick_o = out_q.tick;
    assign clk_o  = out_q.sqw;

endmodule

// File: rtl/multi_clock_divider.sv
// CHANNELS independent programmable dividers sharing one clock; tick_o is the
// clock enable for downstream logic, clk_o is for pins and indicators only.
module multi_clock_divider
    import multi_clock_divider_pkg::*;
#(
    parameter  int CHANNELS  = 4,
    parameter  int CNT_WIDTH = DEF_CNT_WIDTH,
    parameter  int DIV_RESET = DEF_DIV_RESET,
    localparam int SEL_W     = sel_width(CHANNELS)
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [CHANNELS-1:0]  en_i,
    input  logic                 load_i,
    input  logic [SEL_W-1:0]     load_sel_i,
    input  logic [CNT_WIDTH-1:0] load_div_i,
    input  logic                 sync_i,
    output logic [CHANNELS-1:0]  tick_o,
    output logic [CHANNELS-1:0]  clk_o
);

    logic                sel_ok_s;
    logic [CHANNELS-1:0] wr_s;

    // Load-select decoder; out-of-range selects write nothing.
    always_comb begin
        wr_s     = '0;
        sel_ok_s = ({1'b0, load_sel_i} < (SEL_W+1)'(CHANNELS));
        for (int i = 0; i < CHANNELS; i++) begin
            wr_s[i] = load_i && sel_ok_s && (load_sel_i == SEL_W'(i));
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        multi_clock_divider_channel #(
            .CNT_WIDTH (CNT_WIDTH),
            .DIV_RESET (DIV_RESET)
        ) u_ch (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .en_i    (en_i[g]),
            .wr_i    (wr_s[g]),
            .div_i   (load_div_i),
            .sync_i  (sync_i),
            .tick_o  (tick_o[g]),
            .clk_o   (clk_o[g])
        );
    end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed bench: stimulus pushes hand-derived per-edge expectations into a
// scoreboard queue, a negedge monitor pops and compares them.
module tb_multi_clock_divider;

    logic       clk = 1'b0;
    logic       reset, load, sync;
    logic [3:0] en;
    logic [1:0] sel;
    logic [7:0] div;
    logic [3:0] tick, sqw;

    logic       load3, sync3;
    logic [2:0] en3;
    logic [1:0] sel3;
    logic [7:0] div3;
    logic [2:0] tick3, sqw3;

    always #5 clk = ~clk;

    multi_clock_divider #(.CHANNELS(4), .CNT_WIDTH(8), .DIV_RESET(3)) u_dut (
        .clk_i(clk), .reset_i(reset), .en_i(en), .load_i(load), .load_sel_i(sel),
        .load_div_i(div), .sync_i(sync), .tick_o(tick), .clk_o(sqw)
    );

    // Three-channel instance so that a select value beyond CHANNELS exists.
    multi_clock_divider #(.CHANNELS(3), .CNT_WIDTH(8), .DIV_RESET(1)) u_dut3 (
        .clk_i(clk), .reset_i(reset), .en_i(en3), .load_i(load3), .load_sel_i(sel3),
        .load_div_i(div3), .sync_i(sync3), .tick_o(tick3), .clk_o(sqw3)
    );

    typedef struct {
        int         at;
        int         unit;
        logic [3:0] tick;
        logic [3:0] sqw;
        logic [3:0] mask;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   r, b, c, s, z;
    int   dv [4];
    logic [3:0] tv, sv;
    logic t1, s1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(input int at, input int unit, input logic [3:0] t,
                                 input logic [3:0] q, input logic [3:0] m, input string name);
        exp_t e;
        e.at = at; e.unit = unit; e.tick = t; e.sqw = q; e.mask = m; e.name = name;
        sb.push_back(e);
    endfunction

    function automatic logic [3:0] d3(input int at);
        return (((at - r) % 2) == 0) ? 4'h7 : 4'h0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [3:0] got_t, got_s;
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e     = sb.pop_front();
            got_t = (e.unit == 0) ? tick : {1'b0, tick3};
            got_s = (e.unit == 0) ? sqw  : {1'b0, sqw3};
            total++;
            if (e.at != cyc) begin
                bad++;
                $display("FAIL %s: check for edge %0d reached at edge %0d", e.name, e.at, cyc);
            end else if (((got_t & e.mask) !== (e.tick & e.mask)) ||
                         ((got_s & e.mask) !== (e.sqw & e.mask))) begin
                bad++;
                $display("FAIL %s @edge %0d: tick=%b clk=%b, want tick=%b clk=%b (mask %b)",
                         e.name, cyc, got_t, got_s, e.tick, e.sqw, e.mask);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; en = 4'h0; load = 1'b0; sel = 2'd0; div = 8'd0; sync = 1'b0;
        en3 = 3'h0; load3 = 1'b0; sel3 = 2'd0; div3 = 8'd0; sync3 = 1'b0;
        step(); step();

        // Reset state, then channel 0 at the reset divisor 3.
        r = cyc;
        push(r, 0, 4'h0, 4'h0, 4'hF, "reset");
        push(r, 1, 4'h0, 4'h0, 4'h7, "reset3");
        reset = 1'b0; en = 4'b0001; en3 = 3'b111;
        for (int k = 1; k <= 12; k++) begin
            push(r + k, 0, {3'b000, (k % 4) == 0}, {3'b000, ((k - 1) % 4) >= 2}, 4'hF, "div3_ch0");
            push(r + k, 1, d3(r + k), d3(r + k), 4'h7, "div1_dut3");
        end
        repeat (12) step();

        // Reload ch0 to D=1 while CNT=1: old period finishes, then period 2.
        b = cyc;
        for (int k = 1; k <= 12; k++) begin
            t1 = (k == 4) || (k > 4 && (k % 2) == 0);
            s1 = (k <= 4) ? (k >= 3) : ((k % 2) == 0);
            push(b + k, 0, {3'b000, t1}, {3'b000, s1}, 4'hF, "reload_d1");
        end
        step();
        load = 1'b1; sel = 2'd0; div = 8'd1;
        step();
        load = 1'b0;
        repeat (10) step();

        // D=0 on ch1; out-of-range select on the 3-channel instance.
        c = cyc;
        for (int k = 1; k <= 10; k++) begin
            if (k >= 3) push(c + k, 0, 4'b0010, 4'b0010, 4'b0010, "d0_ch1");
            push(c + k, 1, d3(c + k), d3(c + k), 4'h7, "sel_oob");
        end
        load = 1'b1; sel = 2'd1; div = 8'd0;
        load3 = 1'b1; sel3 = 2'd3; div3 = 8'd0;
        step();
        load = 1'b0; load3 = 1'b0;
        step();
        en = 4'b0011;
        repeat (8) step();

        // Divisors 2,4,4,6, staggered enables, then SYNC.
        en = 4'h0;
        step();
        load = 1'b1;
        sel = 2'd0; div = 8'd2; step();
        sel = 2'd1; div = 8'd4; step();
        sel = 2'd2; div = 8'd4; step();
        sel = 2'd3; div = 8'd6; step();
        load = 1'b0; step();
        en = 4'b0011; repeat (3) step();
        en = 4'b1111; repeat (4) step();
        sync = 1'b1;
        s = cyc + 1;
        dv[0] = 2; dv[1] = 4; dv[2] = 4; dv[3] = 6;
        for (int k = 1; k <= 14; k++) begin
            for (int ch = 0; ch < 4; ch++) begin
                tv[ch] = (k % (dv[ch] + 1)) == 0;
                sv[ch] = ((k - 1) % (dv[ch] + 1)) >= ((dv[ch] + 1) / 2);
            end
            push(s + k, 0, tv, sv, 4'hF, "sync");
        end
        step();
        sync = 1'b0;
        repeat (14) step();

        // Ch2: pending D=5, then D=9 loaded on the wrap that applies D=5.
        for (int k = 16; k <= 46; k++) begin
            if (k <= 20) begin
                t1 = (k % 5) == 0;  s1 = ((k - 1) % 5) >= 2;
            end else if (k <= 26) begin
                t1 = (k == 26);     s1 = (k - 21) >= 3;
            end else begin
                t1 = ((k - 26) % 10) == 0; s1 = ((k - 27) % 10) >= 5;
            end
            push(s + k, 0, {1'b0, t1, 2'b00}, {1'b0, s1, 2'b00}, 4'b0100, "wrap_load");
        end
        for (int k = 15; k <= 46; k++) begin
            load = (k == 16) || (k == 20);
            sel  = 2'd2;
            div  = (k == 16) ? 8'd5 : 8'd9;
            step();
        end
        load = 1'b0;

        // Reset mid-period with a pending load on ch3.
        load = 1'b1; sel = 2'd3; div = 8'd2;
        step();
        load = 1'b0; reset = 1'b1;
        z = cyc + 1;
        push(z, 0, 4'h0, 4'h0, 4'hF, "reset_mid");
        push(z, 1, 4'h0, 4'h0, 4'h7, "reset_mid3");
        for (int k = 1; k <= 12; k++) begin
            push(z + k, 0, {4{(k % 4) == 0}}, {4{((k - 1) % 4) >= 2}}, 4'hF, "after_reset");
        end
        step();
        reset = 1'b0;
        repeat (12) step();

        for (int i = 0; i < 20 && sb.size() > 0; i++) step();
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d checks never reached, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
